// File: rtl/spi_reg_bank.sv
// SPI-slave register bank: command/data byte protocol over an SPI byte peripheral plus a fabric-side host port.
// Define SPI_REG_AUTOINC_EN to make WRITE_DATA/READ_DATA auto-increment the address for burst access.
module spi_reg_bank #(
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter int         ADDR_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_dv,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_spi_cs_n,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [7:0]        i_host_wdata,
    output logic [7:0]        o_host_rdata,
    output logic              o_wr_strobe,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WRITE_DATA, READ_DATA, IGNORE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          regs_q [DEPTH];
    logic [7:0]          regs_d [DEPTH];
    logic                cs_meta_q, cs_sync_q, cs_prev_q;
    logic                startup_q, startup_d;
    logic                tx_dv_q, tx_dv_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                pend_q, pend_d;
    logic [7:0]          pend_byte_q, pend_byte_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

    logic                frame_end;
    logic                cmd_ok;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   addr_inc;
    logic                req;
    logic [7:0]          req_byte;

    assign frame_end    = cs_sync_q & ~cs_prev_q;
    assign cmd_ok       = ((i_rx_byte[6:0] >> ADDR_W) == 7'd0);
    assign cmd_addr     = i_rx_byte[ADDR_W-1:0];
    assign addr_inc     = addr_q + 1'b1;
    assign o_host_rdata = regs_q[i_host_addr];

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        startup_d   = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        req         = 1'b0;
        req_byte    = STATUS_BYTE;

        // Host write goes first so an SPI write to the same address overrides it.
        if (i_host_we) regs_d[i_host_addr] = i_host_wdata;

        if (frame_end) begin
            state_d  = IDLE;
            req      = 1'b1;
            req_byte = STATUS_BYTE;
        end else if (i_rx_dv) begin
            case (state_q)
                IDLE: begin
                    if (!cmd_ok) begin
                        state_d = IGNORE;
                    end else if (i_rx_byte[7]) begin
                        addr_d  = cmd_addr;
                        state_d = WRITE_DATA;
                    end else begin
                        addr_d   = cmd_addr;
                        state_d  = READ_DATA;
                        req      = 1'b1;
                        req_byte = regs_q[cmd_addr];
                    end
                end
                WRITE_DATA: begin
                    regs_d[addr_q] = i_rx_byte;
                    wr_strobe_d    = 1'b1;
                    wr_addr_d      = addr_q;
`ifdef SPI_REG_AUTOINC_EN
                    addr_d = addr_inc;
`else
                    state_d = IGNORE;
`endif
                end
                READ_DATA: begin
`ifdef SPI_REG_AUTOINC_EN
                    addr_d   = addr_inc;
                    req      = 1'b1;
                    req_byte = regs_q[addr_inc];
`else
                    state_d = IGNORE;
`endif
                end
                default: ;
            endcase
        end

        if (startup_q) begin
            req      = 1'b1;
            req_byte = STATUS_BYTE;
        end

        // A reload requested right after a pulse is deferred one cycle so o_tx_dv never stays high.
        tx_dv_d     = 1'b0;
        tx_byte_d   = tx_byte_q;
        pend_d      = 1'b0;
        pend_byte_d = pend_byte_q;
        if (tx_dv_q) begin
            pend_d = req | pend_q;
            if (req) pend_byte_d = req_byte;
        end else if (req || pend_q) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = req ? req_byte : pend_byte_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            startup_q   <= 1'b1;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            // NOTE: the bank is cleared on reset because its contents are architecturally visible.
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cs_meta_q   <= i_spi_cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            startup_q   <= startup_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    assign o_tx_dv     = tx_dv_q;
    assign o_tx_byte   = tx_byte_q;
    assign o_wr_strobe = wr_strobe_q;
    assign o_wr_addr   = wr_addr_q;

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter STATUS_BYTE, default 8'hA5: byte preloaded for the SPI peripheral to shift out during a command byte.
REQ-002 Parameter ADDR_W, default 4: register address width; the bank SHALL hold 2**ADDR_W 8-bit registers.
REQ-003 i_clk  input  1  single FPGA clock; all logic SHALL be on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_rx_byte  input  8  received byte from the SPI peripheral.
REQ-006 i_rx_dv  input  1  one-cycle pulse: i_rx_byte is valid.
REQ-007 o_tx_dv  output  1  one-cycle pulse: load o_tx_byte into the peripheral.
REQ-008 o_tx_byte  output  8  next byte to be shifted out on CIPO.
REQ-009 i_spi_cs_n  input  1  raw chip select, active low, asynchronous to i_clk.
REQ-010 i_host_we  input  1  fabric-side register write enable.
REQ-011 i_host_addr  input  ADDR_W  fabric-side register address.
REQ-012 i_host_wdata  input  8  fabric-side write data.
REQ-013 o_host_rdata  output  8  combinational read of reg[i_host_addr].
REQ-014 o_wr_strobe  output  1  one-cycle pulse on every SPI-originated register write.
REQ-015 o_wr_addr  output  ADDR_W  address of the SPI write flagged by o_wr_strobe.

Function
REQ-016 i_spi_cs_n SHALL pass through a 2-flop synchroniser; a synchronised 0->1 transition SHALL be the frame-end event.
REQ-017 Command byte: bit7 = 1 write / 0 read, bits[6:ADDR_W] must be zero, bits[ADDR_W-1:0] = address.
REQ-018 FSM states: IDLE, WRITE_DATA, READ_DATA, IGNORE.
REQ-019 IDLE + i_rx_dv with valid write command -> latch address, go WRITE_DATA.
REQ-020 IDLE + i_rx_dv with valid read command -> latch address, pulse o_tx_dv with o_tx_byte = reg[addr] on the next cycle, go READ_DATA.
REQ-021 IDLE + i_rx_dv with nonzero reserved bits -> go IGNORE; no register change.
REQ-022 WRITE_DATA + i_rx_dv -> reg[addr] <= i_rx_byte; o_wr_strobe = 1 and o_wr_addr = addr in the cycle after i_rx_dv; then go IGNORE.
REQ-023 READ_DATA + i_rx_dv -> byte discarded; go IGNORE.
REQ-024 IGNORE SHALL discard all i_rx_dv bytes until frame end.
REQ-025 On frame end, from any state: go IDLE; pulse o_tx_dv with o_tx_byte = STATUS_BYTE on the next cycle.
REQ-026 Frame end and i_rx_dv in the same cycle: frame end wins; the byte SHALL be dropped.
REQ-027 SPI write and i_host_we to the same address in the same cycle: SPI write wins; different addresses: both SHALL complete.
REQ-028 o_tx_dv SHALL never be high in two consecutive cycles; o_tx_byte SHALL hold its value between pulses.

Reset
REQ-029 While i_reset is high: all registers 0, FSM in IDLE, address 0, o_tx_dv = 0, o_tx_byte = 0, o_wr_strobe = 0, o_wr_addr = 0, synchroniser flops = 1.
REQ-030 On the first cycle after i_reset falls, o_tx_dv SHALL pulse with o_tx_byte = STATUS_BYTE.
REQ-031 Reset mid-frame SHALL abandon the transaction with no register update.

Configuration
REQ-032 Macro SPI_REG_AUTOINC_EN defined: after the data byte in WRITE_DATA or READ_DATA, the address SHALL increment modulo 2**ADDR_W and the FSM SHALL remain in that state; in READ_DATA it SHALL pulse o_tx_dv with reg[addr+1].
REQ-033 SPI_REG_AUTOINC_EN undefined: the single-access transitions to IGNORE of REQ-022/REQ-023 SHALL apply.

Verification
REQ-034 Reset released -> o_tx_dv pulses once, o_tx_byte = 8'hA5; o_host_rdata = 0 for every address.
REQ-035 CS low, rx 8'h83 then 8'h5C, CS high -> reg[3] = 8'h5C, one o_wr_strobe with o_wr_addr = 3, then STATUS_BYTE reload.
REQ-036 Host writes reg[7] = 8'h3E; SPI rx 8'h07 -> next-cycle o_tx_dv with o_tx_byte = 8'h3E; a second rx byte produces no reload until CS rises.
REQ-037 SPI rx 8'h90 (reserved bit set) then 8'hFF -> no register changes, no o_wr_strobe.
REQ-038 With SPI_REG_AUTOINC_EN: rx 8'h8F, 8'h11, 8'h22 -> reg[15] = 8'h11, reg[0] = 8'h22 (wrap-around); without it: reg[0] unchanged.
REQ-039 CS rising in the same cycle as i_rx_dv of a write data byte -> no register update; FSM returns to IDLE with STATUS_BYTE reload.
